// File: rtl/t2mi_ts_encapsulator_pkg.sv
// Shared constants and FSM encoding for the T2-MI to TS encapsulator.
package t2mi_ts_encapsulator_pkg;

    localparam int          TS_PKT_LEN = 188;
    localparam int          TS_PAY_LEN = 184;
    localparam int          TS_HDR_LEN = TS_PKT_LEN - TS_PAY_LEN;
    localparam logic [7:0]  TS_SYNC    = 8'h47;
    localparam logic [12:0] NULL_PID   = 13'h1FFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HDR      = 3'd1,
        PTR      = 3'd2,
        PAY      = 3'd3,
        NULL_PAY = 3'd4
    } ts_state_t;

endpackage

// File: rtl/t2mi_ts_encapsulator_fifo.sv
// Show-ahead single-clock FIFO; head word is visible on rd_data while not empty.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [AW:0]      level
);
    logic [WIDTH-1:0] mem [0:(1<<AW)-1];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (level == '0);
    assign do_wr   = wr_en & ~level[AW];
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK) begin
        if (do_wr)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_rd)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/t2mi_ts_encapsulator.sv
// Buffers a bursty T2-MI byte stream and emits it as 188-byte TS packets,
// optionally filling idle time with null packets.
module t2mi_ts_encapsulator
    import t2mi_ts_encapsulator_pkg::*;
#(
    parameter int DATA_AW = 13,
    parameter int SOP_AW  = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       DATA_IN,
    input  logic             ENA_IN,
    input  logic             SOP_IN,
    input  logic [12:0]      PID,
    input  logic             NULL_FILL,
    input  logic             OUT_RDY,
    output logic [7:0]       TS_DATA,
    output logic             TS_VALID,
    output logic             TS_SOP,
    output logic             OVERFLOW,
    output logic [DATA_AW:0] FIFO_LEVEL,
    output logic [2:0]       state_mon
);
    localparam int LW = DATA_AW + 1;

    ts_state_t        state;
    ts_state_t        state_n;
    logic [7:0]       cnt;
    logic [7:0]       cnt_n;
    logic [15:0]      wr_cnt;
    logic [15:0]      rd_cnt;
    logic [15:0]      sop_head;
    logic [15:0]      delta;
    logic [12:0]      pid_q;
    logic [7:0]       ptr_q;
    logic [7:0]       data_head;
    logic [7:0]       hdr_byte;
    logic [7:0]       ld_data;
    logic [7:0]       ts_data;
    logic [3:0]       cc;
    logic             pusi_q;
    logic             null_q;
    logic             ts_valid;
    logic             ts_sop;
    logic             overflow;
    logic [DATA_AW:0] data_level;
    logic [SOP_AW:0]  sop_level;
    logic             data_empty;
    logic             sop_empty;
    logic             data_full;
    logic             sop_full;
    logic             data_wr;
    logic             sop_wr;
    logic             data_pop;
    logic             sop_pop;
    logic             adv;
    logic             have_pay;
    logic             pusi_d;
    logic             load;
    logic             ld_sop;
    logic             decide;
    logic             pop;
    logic             cc_inc;

    assign data_full = data_level[DATA_AW];
    assign sop_full  = sop_level[SOP_AW];
    assign data_wr   = ENA_IN & ~data_full;
    assign sop_wr    = data_wr & SOP_IN;
    assign data_pop  = pop & ~data_empty;
    assign sop_pop   = data_pop & ~sop_empty & (rd_cnt == sop_head);
    assign adv       = ~ts_valid | OUT_RDY;
    assign have_pay  = data_level >= LW'(TS_PAY_LEN);
    assign delta     = sop_head - rd_cnt;
    assign pusi_d    = ~sop_empty & (delta < 16'd183);

    sync_fifo_fwft #(
        .WIDTH (8),
        .AW    (DATA_AW)
    ) u_data_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (data_wr),
        .wr_data (DATA_IN),
        .rd_en   (data_pop),
        .rd_data (data_head),
        .empty   (data_empty),
        .level   (data_level)
    );

    // Holds the wr_cnt stamp of every buffered packet start.
    sync_fifo_fwft #(
        .WIDTH (16),
        .AW    (SOP_AW)
    ) u_sop_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (sop_wr),
        .wr_data (wr_cnt),
        .rd_en   (sop_pop),
        .rd_data (sop_head),
        .empty   (sop_empty),
        .level   (sop_level)
    );

    // Null packets latch NULL_PID with PUSI clear, so one mux serves both.
    always_comb begin
        hdr_byte = {4'h1, null_q ? 4'h0 : cc};
        unique case (1'b1)
            (cnt == 8'd1): hdr_byte = {1'b0, pusi_q, 1'b0, pid_q[12:8]};
            (cnt == 8'd2): hdr_byte = pid_q[7:0];
            default:       ;
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        load    = 1'b0;
        ld_data = 8'h00;
        ld_sop  = 1'b0;
        decide  = 1'b0;
        pop     = 1'b0;
        cc_inc  = 1'b0;
        if (adv) begin
            unique case (state)
                IDLE: begin
                    if (have_pay || NULL_FILL) begin
                        decide  = 1'b1;
                        load    = 1'b1;
                        ld_data = TS_SYNC;
                        ld_sop  = 1'b1;
                        cnt_n   = 8'd1;
                        state_n = HDR;
                    end
                end
                HDR: begin
                    load    = 1'b1;
                    ld_data = hdr_byte;
                    cnt_n   = cnt + 8'd1;
                    if (cnt == 8'(TS_HDR_LEN - 1)) begin
                        cnt_n   = 8'd0;
                        state_n = null_q ? NULL_PAY : (pusi_q ? PTR : PAY);
                    end
                end
                PTR: begin
                    load    = 1'b1;
                    ld_data = ptr_q;
                    state_n = PAY;
                end
                PAY: begin
                    load    = 1'b1;
                    ld_data = data_head;
                    pop     = 1'b1;
                    cnt_n   = cnt + 8'd1;
                    if (cnt == (pusi_q ? 8'd182 : 8'd183)) begin
                        cnt_n   = 8'd0;
                        cc_inc  = 1'b1;
                        state_n = IDLE;
                    end
                end
                NULL_PAY: begin
                    load    = 1'b1;
                    ld_data = 8'hFF;
                    cnt_n   = cnt + 8'd1;
                    if (cnt == 8'(TS_PAY_LEN - 1)) begin
                        cnt_n   = 8'd0;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pusi_q   <= 1'b0;
            null_q   <= 1'b0;
            ptr_q    <= 8'h00;
            pid_q    <= 13'h0000;
            cc       <= 4'h0;
            ts_data  <= 8'h00;
            ts_valid <= 1'b0;
            ts_sop   <= 1'b0;
            wr_cnt   <= 16'h0000;
            rd_cnt   <= 16'h0000;
            overflow <= 1'b0;
        end else begin
            if (decide) begin
                pusi_q <= have_pay & pusi_d;
                null_q <= ~have_pay;
                ptr_q  <= delta[7:0];
                pid_q  <= have_pay ? PID : NULL_PID;
            end
            if (cc_inc)
                cc <= cc + 4'd1;
            if (adv) begin
                ts_valid <= load;
                ts_sop   <= ld_sop;
                if (load)
                    ts_data <= ld_data;
            end
            if (data_wr)
                wr_cnt <= wr_cnt + 16'd1;
            if (data_pop)
                rd_cnt <= rd_cnt + 16'd1;
            if (ENA_IN & (data_full | (SOP_IN & sop_full)))
                overflow <= 1'b1;
        end
    end

    assign TS_DATA    = ts_data;
    assign TS_VALID   = ts_valid;
    assign TS_SOP     = ts_sop;
    assign OVERFLOW   = overflow;
    assign FIFO_LEVEL = data_level;
    assign state_mon  = state;

endmodule

// File: tb/tb_t2mi_ts_encapsulator.sv
// Directed bench for t2mi_ts_encapsulator; each task checks one scenario.
module tb_t2mi_ts_encapsulator;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  DATA_IN = 8'h00;
    logic        ENA_IN = 1'b0;
    logic        SOP_IN = 1'b0;
    logic [12:0] PID = 13'h0ABC;
    logic        NULL_FILL = 1'b0;
    logic        OUT_RDY = 1'b1;
    logic [7:0]  TS_DATA;
    logic        TS_VALID;
    logic        TS_SOP;
    logic        OVERFLOW;
    logic [13:0] FIFO_LEVEL;
    logic [2:0]  state_mon;

    int vectors = 0;
    int miscompares = 0;
    logic [8:0] cap[$];
    logic [8:0] exp_q[$];

    t2mi_ts_encapsulator #(.DATA_AW(13), .SOP_AW(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .DATA_IN    (DATA_IN),
        .ENA_IN     (ENA_IN),
        .SOP_IN     (SOP_IN),
        .PID        (PID),
        .NULL_FILL  (NULL_FILL),
        .OUT_RDY    (OUT_RDY),
        .TS_DATA    (TS_DATA),
        .TS_VALID   (TS_VALID),
        .TS_SOP     (TS_SOP),
        .OVERFLOW   (OVERFLOW),
        .FIFO_LEVEL (FIFO_LEVEL),
        .state_mon  (state_mon)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK)
        if (RST && TS_VALID && OUT_RDY)
            cap.push_back({TS_SOP, TS_DATA});

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RST = 1'b0;
        ENA_IN = 1'b0;
        SOP_IN = 1'b0;
        repeat (2) tick();
        RST = 1'b1;
        tick();
        cap.delete();
    endtask

    task automatic write_bytes(input int n, input int s0, input int s1,
                               input logic [7:0] salt);
        for (int i = 0; i < n; i++) begin
            DATA_IN = 8'(i) ^ salt;
            SOP_IN = (i == s0) || (i == s1);
            ENA_IN = 1'b1;
            tick();
        end
        ENA_IN = 1'b0;
        SOP_IN = 1'b0;
    endtask

    task automatic wait_cap(input int n, input int budget, input string name,
                            output bit ok);
        int k = 0;
        while (cap.size() < n && k < budget) begin
            tick();
            k++;
        end
        vectors++;
        ok = (cap.size() >= n);
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: captured %0d bytes, required %0d", name, cap.size(), n);
        end
    endtask

    // Expected packet as {sop, byte}; payload byte i of the stream is 8'(i)^salt.
    function automatic void build_pkt(input bit nul, input bit pusi,
                                      input logic [7:0] ptr, input logic [3:0] cc,
                                      input logic [12:0] pid, input int start,
                                      input logic [7:0] salt);
        int np;
        exp_q.delete();
        exp_q.push_back(9'h147);
        if (nul) begin
            exp_q.push_back(9'h01F);
            exp_q.push_back(9'h0FF);
            exp_q.push_back(9'h010);
            for (int i = 0; i < 184; i++) exp_q.push_back(9'h0FF);
        end else begin
            exp_q.push_back({1'b0, 1'b0, pusi, 1'b0, pid[12:8]});
            exp_q.push_back({1'b0, pid[7:0]});
            exp_q.push_back({1'b0, 4'h1, cc});
            if (pusi) exp_q.push_back({1'b0, ptr});
            np = pusi ? 183 : 184;
            for (int i = 0; i < np; i++) exp_q.push_back({1'b0, 8'(start + i) ^ salt});
        end
    endfunction

    task automatic test_reset();
        RST = 1'b0;
        NULL_FILL = 1'b0;
        tick();
        vectors += 6;
        if (TS_DATA !== 8'h00) begin miscompares++; $display("FAIL rst_data: got %h, required 00", TS_DATA); end
        if (TS_VALID !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b, required 0", TS_VALID); end
        if (TS_SOP !== 1'b0) begin miscompares++; $display("FAIL rst_sop: got %b, required 0", TS_SOP); end
        if (OVERFLOW !== 1'b0) begin miscompares++; $display("FAIL rst_ovf: got %b, required 0", OVERFLOW); end
        if (FIFO_LEVEL !== 14'd0) begin miscompares++; $display("FAIL rst_level: got %0d, required 0", FIFO_LEVEL); end
        if (state_mon !== 3'd0) begin miscompares++; $display("FAIL rst_state: got %0d, required 0", state_mon); end
    endtask

    task automatic test_two_packets();
        bit ok;
        OUT_RDY = 1'b1;
        NULL_FILL = 1'b0;
        apply_reset();
        write_bytes(400, 0, 200, 8'h00);
        wait_cap(376, 600, "t1_bytes", ok);
        if (!ok) return;
        build_pkt(0, 1, 8'h00, 4'd0, PID, 0, 8'h00);
        for (int j = 0; j < 188; j++) begin
            vectors++;
            if (cap[j] !== exp_q[j]) begin
                miscompares++;
                $display("FAIL t1_pkt1[%0d]: got %h, required %h", j, cap[j], exp_q[j]);
            end
        end
        build_pkt(0, 1, 8'h11, 4'd1, PID, 183, 8'h00);
        for (int j = 0; j < 188; j++) begin
            vectors++;
            if (cap[188 + j] !== exp_q[j]) begin
                miscompares++;
                $display("FAIL t1_pkt2[%0d]: got %h, required %h", j, cap[188 + j], exp_q[j]);
            end
        end
        repeat (300) tick();
        vectors += 2;
        if (cap.size() != 376) begin miscompares++; $display("FAIL t1_count: got %0d, required 376", cap.size()); end
        if (FIFO_LEVEL !== 14'd34) begin miscompares++; $display("FAIL t1_level: got %0d, required 34", FIFO_LEVEL); end
    endtask

    task automatic test_null_fill();
        bit ok;
        int k;
        OUT_RDY = 1'b1;
        NULL_FILL = 1'b1;
        apply_reset();
        wait_cap(188, 400, "t2_null_bytes", ok);
        if (!ok) return;
        build_pkt(1, 0, 8'h00, 4'd0, 13'h0, 0, 8'h00);
        for (int j = 0; j < 188; j++) begin
            vectors++;
            if (cap[j] !== exp_q[j]) begin
                miscompares++;
                $display("FAIL t2_null[%0d]: got %h, required %h", j, cap[j], exp_q[j]);
            end
        end
        NULL_FILL = 1'b0;
        k = 0;
        while (state_mon !== 3'd0 && k < 400) begin tick(); k++; end
        repeat (2) tick();
        cap.delete();
        write_bytes(184, -1, -1, 8'h3C);
        wait_cap(188, 400, "t2_data_bytes", ok);
        if (!ok) return;
        build_pkt(0, 0, 8'h00, 4'd0, PID, 0, 8'h3C);
        for (int j = 0; j < 188; j++) begin
            vectors++;
            if (cap[j] !== exp_q[j]) begin
                miscompares++;
                $display("FAIL t2_cc_kept[%0d]: got %h, required %h", j, cap[j], exp_q[j]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [7:0] hd;
        logic hv;
        OUT_RDY = 1'b1;
        NULL_FILL = 1'b0;
        apply_reset();
        write_bytes(184, -1, -1, 8'hA5);
        wait_cap(60, 300, "t3_pre", ok);
        if (!ok) return;
        OUT_RDY = 1'b0;
        hd = TS_DATA;
        hv = TS_VALID;
        vectors++;
        if (hv !== 1'b1) begin miscompares++; $display("FAIL t3_valid_mid: got %b, required 1", hv); end
        for (int c = 0; c < 5; c++) begin
            tick();
            vectors += 2;
            if (TS_DATA !== hd) begin miscompares++; $display("FAIL t3_hold_data[%0d]: got %h, required %h", c, TS_DATA, hd); end
            if (TS_VALID !== 1'b1) begin miscompares++; $display("FAIL t3_hold_valid[%0d]: got %b, required 1", c, TS_VALID); end
        end
        OUT_RDY = 1'b1;
        wait_cap(188, 400, "t3_bytes", ok);
        if (!ok) return;
        build_pkt(0, 0, 8'h00, 4'd0, PID, 0, 8'hA5);
        for (int j = 0; j < 188; j++) begin
            vectors++;
            if (cap[j] !== exp_q[j]) begin
                miscompares++;
                $display("FAIL t3_seq[%0d]: got %h, required %h", j, cap[j], exp_q[j]);
            end
        end
        vectors++;
        if (FIFO_LEVEL !== 14'd0) begin miscompares++; $display("FAIL t3_level: got %0d, required 0", FIFO_LEVEL); end
    endtask

    task automatic test_cc_no_sop();
        bit ok;
        OUT_RDY = 1'b1;
        NULL_FILL = 1'b0;
        PID = 13'h1234;
        apply_reset();
        write_bytes(17 * 184, -1, -1, 8'h00);
        wait_cap(17 * 188, 2000, "t4_bytes", ok);
        if (!ok) return;
        for (int p = 0; p < 17; p++) begin
            build_pkt(0, 0, 8'h00, 4'(p), PID, 184 * p, 8'h00);
            for (int j = 0; j < 188; j++) begin
                vectors++;
                if (cap[188 * p + j] !== exp_q[j]) begin
                    miscompares++;
                    $display("FAIL t4_pkt%0d[%0d]: got %h, required %h", p, j, cap[188 * p + j], exp_q[j]);
                end
            end
        end
        PID = 13'h0ABC;
    endtask

    task automatic test_overflow();
        bit ok;
        OUT_RDY = 1'b0;
        NULL_FILL = 1'b0;
        apply_reset();
        write_bytes(8192, 0, -1, 8'h5A);
        vectors += 2;
        if (FIFO_LEVEL !== 14'd8192) begin miscompares++; $display("FAIL t5_full_level: got %0d, required 8192", FIFO_LEVEL); end
        if (OVERFLOW !== 1'b0) begin miscompares++; $display("FAIL t5_no_ovf: got %b, required 0", OVERFLOW); end
        write_bytes(1, -1, -1, 8'hEE);
        vectors += 2;
        if (FIFO_LEVEL !== 14'd8192) begin miscompares++; $display("FAIL t5_sat_level: got %0d, required 8192", FIFO_LEVEL); end
        if (OVERFLOW !== 1'b1) begin miscompares++; $display("FAIL t5_ovf_set: got %b, required 1", OVERFLOW); end
        OUT_RDY = 1'b1;
        wait_cap(188, 400, "t5_bytes", ok);
        if (ok) begin
            build_pkt(0, 1, 8'h00, 4'd0, PID, 0, 8'h5A);
            for (int j = 0; j < 188; j++) begin
                vectors++;
                if (cap[j] !== exp_q[j]) begin
                    miscompares++;
                    $display("FAIL t5_pkt[%0d]: got %h, required %h", j, cap[j], exp_q[j]);
                end
            end
        end
        repeat (100) tick();
        vectors++;
        if (OVERFLOW !== 1'b1) begin miscompares++; $display("FAIL t5_ovf_sticky: got %b, required 1", OVERFLOW); end
        RST = 1'b0;
        tick();
        vectors++;
        if (OVERFLOW !== 1'b0) begin miscompares++; $display("FAIL t5_ovf_clr: got %b, required 0", OVERFLOW); end
        RST = 1'b1;
    endtask

    task automatic test_reset_mid_pay();
        bit ok;
        OUT_RDY = 1'b1;
        NULL_FILL = 1'b0;
        apply_reset();
        write_bytes(400, 0, -1, 8'h00);
        vectors++;
        if (state_mon !== 3'd3) begin miscompares++; $display("FAIL t6_in_pay: got %0d, required 3", state_mon); end
        RST = 1'b0;
        tick();
        vectors += 4;
        if (TS_VALID !== 1'b0) begin miscompares++; $display("FAIL t6_valid: got %b, required 0", TS_VALID); end
        if (FIFO_LEVEL !== 14'd0) begin miscompares++; $display("FAIL t6_level: got %0d, required 0", FIFO_LEVEL); end
        if (OVERFLOW !== 1'b0) begin miscompares++; $display("FAIL t6_ovf: got %b, required 0", OVERFLOW); end
        if (state_mon !== 3'd0) begin miscompares++; $display("FAIL t6_state: got %0d, required 0", state_mon); end
        RST = 1'b1;
        tick();
        cap.delete();
        write_bytes(184, -1, -1, 8'hC3);
        wait_cap(188, 400, "t6_bytes", ok);
        if (!ok) return;
        build_pkt(0, 0, 8'h00, 4'd0, PID, 0, 8'hC3);
        for (int j = 0; j < 188; j++) begin
            vectors++;
            if (cap[j] !== exp_q[j]) begin
                miscompares++;
                $display("FAIL t6_cc0[%0d]: got %h, required %h", j, cap[j], exp_q[j]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_packets();
        test_null_fill();
        test_backpressure();
        test_cc_no_sop();
        test_overflow();
        test_reset_mid_pay();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
